id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- Decode/execute pipeline register of the RV32 core.
- Captures the gated control bundle from the decode control-zeroing mux, plus operands, immediate, PC and register indices.
- Presents them to the execute stage one cycle later.
- Also computes the load-use hazard flag. This flag drives the control-zeroing select and the PC/IF-ID write enables upstream, so the register is both consumer and producer of the decode-stage stall.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- REGW, 5, register index width.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all stage contents
- flush  input  1  insert bubble (taken branch/jump resolved in EX)
- valid_id  input  1  decode slot holds a real instruction
- aluop_id  input  5  ALU control
- alusrc_id, memtoreg_id, regwrite_id, memread_id, memwrite_id, sign_id  input  1 each  decode control bits
- branch_id  input  3  branch type
- length_id  input  2  load/store size
- pc_id, rs1data_id, rs2data_id, imm_id  input  XLEN each  decode datapath values
- rs1_id, rs2_id, rd_id  input  REGW each  register indices
- <each *_id field>_ex  output  same width  registered copy (aluop_ex, ..., rd_ex)
- valid_ex  output  1  EX slot holds a real instruction
- load_use  output  1  combinational hazard flag to upstream stall logic

Behaviour:
- Reset: all *_ex outputs and valid_ex are 0 on the first rising edge with reset=1. load_use is therefore 0.
- Latency: 1 cycle from *_id to *_ex.
- Per-edge priority: reset > flush > stall > load.
- flush=1:
  - valid_ex, aluop_ex, alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex, sign_ex, branch_ex and length_ex become 0.
  - Datapath fields (pc/rs1data/rs2data/imm/rs1/rs2/rd) also become 0.
  - Flush wins over a simultaneous stall.
- stall=1 with flush=0: every register holds its value, including valid_ex.
- Load (stall=0, flush=0):
  - All fields take their *_id values; valid_ex takes valid_id.
  - Safety gating: if valid_id=0, then regwrite_ex, memread_ex, memwrite_ex and branch_ex load 0 regardless of their inputs. Datapath fields load normally.
- load_use (combinational) is 1 only when all of the following hold:
  - valid_ex=1
  - memread_ex=1
  - rd_ex != 0
  - valid_id=1
  - rd_ex equals rs1_id or rs2_id
- load_use consequences:
  - Upstream uses load_use to zero the decode controls and hold PC/IF-ID for exactly one cycle.
  - This block does not itself stall on load_use; the bubble arrives via valid_id/controls.
- x0 as a destination (rd_ex = 0) never raises load_use.
- Reset asserted mid-stall or mid-flush: reset result applies on that edge. Held contents are discarded.
- No internal combinational path from stall/flush to outputs. Only load_use is combinational, and only from *_ex state and *_id inputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN
- Defined:
  - Adds output bubble_cnt, 32 bits, reset to 0.
  - Increments by 1 on each non-stalled, non-reset edge that loads a bubble, i.e. flush=1, or stall=0 with valid_id=0.
  - Saturates at 0xFFFFFFFF.
  - Stall cycles do not count, except when flush is also asserted.
- Undefined: port and counter logic absent. All other behaviour identical.

Test Plan:
1. Reset: drive all *_id inputs to nonzero values, reset=1 for 2 cycles -> all *_ex=0, valid_ex=0, load_use=0.
2. Normal load: valid_id=1, aluop_id=5'h0A, pc_id=32'h0000_0040, rd_id=5 -> next cycle aluop_ex=5'h0A, pc_ex=32'h40, rd_ex=5, valid_ex=1.
3. Stall vs flush:
   - Load pc_id=32'h100, then stall=1 for 3 cycles with pc_id=32'h104 -> pc_ex stays 32'h100.
   - Then stall=1 together with flush=1 -> valid_ex=0, regwrite_ex=0, pc_ex=0.
4. Load-use:
   - EX holds memread_ex=1, rd_ex=7; ID presents valid_id=1, rs2_id=7 -> load_use=1.
   - Same with rd_ex=0 -> load_use=0.
   - Same with valid_ex=0 -> load_use=0.
5. Bubble gating: valid_id=0, regwrite_id=1, memwrite_id=1, branch_id=3'b101 -> next cycle regwrite_ex=0, memwrite_ex=0, branch_ex=0, valid_ex=0.
6. With ID_EX_PERF_CNT_EN:
   - 4 flush edges + 2 bubble loads + 3 pure stall cycles -> bubble_cnt=6.
   - Preload near the maximum -> count holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_reg.sv
// Decode/execute pipeline register with load-use hazard detection.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_id,
  input  logic [4:0]      aluop_id,
  input  logic            alusrc_id,
  input  logic            memtoreg_id,
  input  logic            regwrite_id,
  input  logic            memread_id,
  input  logic            memwrite_id,
  input  logic            sign_id,
  input  logic [2:0]      branch_id,
  input  logic [1:0]      length_id,
  input  logic [XLEN-1:0] pc_id,
  input  logic [XLEN-1:0] rs1data_id,
  input  logic [XLEN-1:0] rs2data_id,
  input  logic [XLEN-1:0] imm_id,
  input  logic [REGW-1:0] rs1_id,
  input  logic [REGW-1:0] rs2_id,
  input  logic [REGW-1:0] rd_id,
  output logic            valid_ex,
  output logic [4:0]      aluop_ex,
  output logic            alusrc_ex,
  output logic            memtoreg_ex,
  output logic            regwrite_ex,
  output logic            memread_ex,
  output logic            memwrite_ex,
  output logic            sign_ex,
  output logic [2:0]      branch_ex,
  output logic [1:0]      length_ex,
  output logic [XLEN-1:0] pc_ex,
  output logic [XLEN-1:0] rs1data_ex,
  output logic [XLEN-1:0] rs2data_ex,
  output logic [XLEN-1:0] imm_ex,
  output logic [REGW-1:0] rs1_ex,
  output logic [REGW-1:0] rs2_ex,
  output logic [REGW-1:0] rd_ex,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]     bubble_cnt,
`endif
  output logic            load_use
);

  // Reset and flush both clear the whole stage to a bubble.
  logic clear_c;
  assign clear_c = reset | flush;

  // Pipeline register; side-effecting controls are squashed for non-valid slots.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      valid_ex    <= 1'b0;
      aluop_ex    <= '0;
      alusrc_ex   <= 1'b0;
      memtoreg_ex <= 1'b0;
      regwrite_ex <= 1'b0;
      memread_ex  <= 1'b0;
      memwrite_ex <= 1'b0;
      sign_ex     <= 1'b0;
      branch_ex   <= '0;
      length_ex   <= '0;
      pc_ex       <= '0;
      rs1data_ex  <= '0;
      rs2data_ex  <= '0;
      imm_ex      <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
    end else if (!stall) begin
      valid_ex    <= valid_id;
      aluop_ex    <= aluop_id;
      alusrc_ex   <= alusrc_id;
      memtoreg_ex <= memtoreg_id;
      regwrite_ex <= regwrite_id & valid_id;
      memread_ex  <= memread_id & valid_id;
      memwrite_ex <= memwrite_id & valid_id;
      sign_ex     <= sign_id;
      branch_ex   <= valid_id ? branch_id : 3'b000;
      length_ex   <= length_id;
      pc_ex       <= pc_id;
      rs1data_ex  <= rs1data_id;
      rs2data_ex  <= rs2data_id;
      imm_ex      <= imm_id;
      rs1_ex      <= rs1_id;
      rs2_ex      <= rs2_id;
      rd_ex       <= rd_id;
    end
  end

  // Load in EX whose destination (not x0) is a source of the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    if (valid_ex && memread_ex && (rd_ex != '0) && valid_id &&
        ((rd_ex == rs1_id) || (rd_ex == rs2_id)))
      load_use = 1'b1;
  end

`ifdef ID_EX_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic bubble_load_c;
  assign bubble_load_c = flush | (~stall & ~valid_id);

  // Saturating count of edges that load a bubble into EX.
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (bubble_load_c && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
`endif

endmodule
